reg_file_rw: RTL and testbench
==============================

Name: reg_file_rw

Overview:
- Parametrised multi-entry register file: one write port, two independent read ports with registered outputs.
- Next-generation storage/readback element for the processor datapath; replaces single-register write-then-read staging.
- Per-port read-valid strobe; per-entry "written" tracking, so reads of never-written entries are flagged rather than silently returning stale data.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 8, number of entries (2..256; need not be a power of two).
- AW, $clog2(DEPTH), address width (derived; not overridden).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous: invalidate all entries.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_en0  in  1  read request, port 0.
- rd_addr0  in  AW  read address, port 0.
- rd_data0  out  WIDTH  registered read data, port 0.
- rd_valid0  out  1  one-cycle pulse: rd_data0/rd_err0 updated.
- rd_err0  out  1  port-0 read hit an unwritten or out-of-range entry.
- rd_en1, rd_addr1, rd_data1, rd_valid1, rd_err1: identical semantics for port 1.
- entry_valid  out  DEPTH  bit i = entry i written since last reset/clear.

Behaviour:
- Reset (async, immediate):
  - all storage words = 0;
  - entry_valid = 0;
  - rd_data0/1 = 0, rd_valid0/1 = 0, rd_err0/1 = 0.
  - Reset asserted mid-operation discards any in-flight read (no rd_valid pulse after reset deasserts).
- Write: wr_en=1 and wr_addr<DEPTH at edge → mem[wr_addr]<=wr_data and entry_valid[wr_addr]<=1. wr_addr>=DEPTH → write ignored, no state change.
- Read latency: exactly 1 cycle.
  - rd_enN=1 at edge k → rd_validN=1 during cycle k+1, with rd_dataN/rd_errN valid.
  - rd_enN=0 → rd_validN=0 next cycle; rd_dataN/rd_errN hold previous values.
- Read result at edge, per port independently:
  - Address out of range → data 0, err 1.
  - Write bypass (write-first): wr_en=1 and wr_addr==rd_addrN (in range) → data = wr_data, err 0.
  - Otherwise entry_valid[addr]=1 → data = mem[addr], err 0.
  - Otherwise data 0, err 1.
- Both ports may read the same address in the same cycle; both return identical results.
- Clear:
  - clear=1 at edge → entry_valid <= 0 except the entry written in that same cycle, which ends valid with the new data.
  - Storage contents are not zeroed by clear.
  - Same-cycle reads use pre-clear valid bits, plus bypass.
- Back-to-back reads every cycle are supported; rd_validN stays high continuously.
- No backpressure: the consumer must capture data on the rd_valid cycle.

Decomposition:
- Shared package (proc_pkg): default WIDTH/DEPTH constants; shared read-response struct {data, err} for datapath consumers.
- One natural sub-module: reg_file_rd_port (address range check, bypass mux, valid/err select, output register), instantiated twice.
- Storage array, entry_valid and write logic stay in the top.

Test Plan:
- Reset then read: reset 2 cycles, rd_en0=1 addr 3 → next cycle rd_valid0=1, rd_data0=0x0000, rd_err0=1; entry_valid=0x00.
- Write/readback: write 0x2933@2, 0x1133@5; next cycle read port0 addr2, port1 addr5 → rd_data0=0x2933, rd_data1=0x1133, both err 0, one-cycle valid pulses; entry_valid=0x24.
- Bypass: same cycle wr_en addr 4 data 0x88F3 and rd_en0 addr 4 → next cycle rd_data0=0x88F3, err 0; a same-cycle port-1 read of addr 4 also returns 0x88F3.
- Clear with simultaneous write: entries 2,5 valid; clear=1 with write 0xABCD@7 → entry_valid=0x80; subsequent read addr 2 → data 0, err 1; read addr 7 → 0xABCD.
- Out-of-range (DEPTH=6): write 0xFFFF@6 → entry_valid unchanged; read addr 7 → data 0, err 1.
- Async reset mid-read: rd_en0=1 at edge k, reset pulses between k and k+1 → rd_valid0=0, rd_data0=0, entry_valid=0 immediately, no late valid pulse.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared datapath package: default register-file geometry and the read
// response record handed to datapath consumers.
package proc_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_DEPTH    = 8;
    localparam int NUM_RD_PORTS = 2;

    // One read result as seen by a consumer on its rd_valid cycle.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 err;
    } rd_rsp_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port of reg_file_rw.
//   clk, reset        : clock, async active-high reset
//   rd_en, rd_addr    : read request
//   wr_hit, wr_addr,
//   wr_data           : qualified (in-range) write of this cycle, for bypass
//   mem, entry_valid  : storage and written flags from the top
//   rd_data, rd_valid,
//   rd_err            : registered result, valid pulse, unwritten/out-of-range flag
module reg_file_rd_port
    import proc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_en,
    input  logic [AW-1:0]               rd_addr,
    input  logic                        wr_hit,
    input  logic [AW-1:0]               wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [DEPTH-1:0][WIDTH-1:0] mem,
    input  logic [DEPTH-1:0]            entry_valid,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid,
    output logic                        rd_err
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic             in_range;
    logic [WIDTH-1:0] nxt_data;
    logic             nxt_err;

    assign in_range = {1'b0, rd_addr} < DEPTH_L;

    // Priority: range check, then write-first bypass, then stored word.
    always_comb begin
        nxt_data = '0;
        nxt_err  = 1'b1;
        if (in_range) begin
            if (wr_hit && wr_addr == rd_addr) begin
                nxt_data = wr_data;
                nxt_err  = 1'b0;
            end else if (entry_valid[rd_addr]) begin
                nxt_data = mem[rd_addr];
                nxt_err  = 1'b0;
            end
        end
    end

    // Data/err hold between reads; only the valid strobe tracks rd_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_err   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= nxt_data;
                rd_err  <= nxt_err;
            end
        end
    end

endmodule

// File: rtl/reg_file_rw.sv
// Multi-entry register file: one write port, two registered read ports
// with valid strobes, and per-entry written tracking.
//   clk, reset     : clock, async active-high reset
//   clear          : sync invalidate of all entries (storage kept)
//   wr_en/addr/data: write port; out-of-range addresses are dropped
//   rd_en*/addr*   : read requests, 1-cycle latency
//   rd_data*/valid*/err* : registered results
//   entry_valid    : bit i set once entry i is written since reset/clear
module reg_file_rw
    import proc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en0,
    input  logic [AW-1:0]    rd_addr0,
    output logic [WIDTH-1:0] rd_data0,
    output logic             rd_valid0,
    output logic             rd_err0,
    input  logic             rd_en1,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    output logic             rd_valid1,
    output logic             rd_err1,
    output logic [DEPTH-1:0] entry_valid
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0]        mem;
    logic                               wr_hit;

    logic [NUM_RD_PORTS-1:0]            rd_en_v;
    logic [NUM_RD_PORTS-1:0][AW-1:0]    rd_addr_v;
    logic [NUM_RD_PORTS-1:0][WIDTH-1:0] rd_data_v;
    logic [NUM_RD_PORTS-1:0]            rd_valid_v;
    logic [NUM_RD_PORTS-1:0]            rd_err_v;

    assign wr_hit = wr_en && ({1'b0, wr_addr} < DEPTH_L);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       mem <= '0;
        else if (wr_hit) mem[wr_addr] <= wr_data;
    end

    // The write is applied after clear so a same-cycle write survives it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_valid <= '0;
        end else begin
            if (clear)  entry_valid <= '0;
            if (wr_hit) entry_valid[wr_addr] <= 1'b1;
        end
    end

    assign rd_en_v   = {rd_en1, rd_en0};
    assign rd_addr_v = {rd_addr1, rd_addr0};

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        reg_file_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_port (
            .clk         (clk),
            .reset       (reset),
            .rd_en       (rd_en_v[p]),
            .rd_addr     (rd_addr_v[p]),
            .wr_hit      (wr_hit),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .mem         (mem),
            .entry_valid (entry_valid),
            .rd_data     (rd_data_v[p]),
            .rd_valid    (rd_valid_v[p]),
            .rd_err      (rd_err_v[p])
        );
    end

    assign rd_data0  = rd_data_v[0];
    assign rd_valid0 = rd_valid_v[0];
    assign rd_err0   = rd_err_v[0];
    assign rd_data1  = rd_data_v[1];
    assign rd_valid1 = rd_valid_v[1];
    assign rd_err1   = rd_err_v[1];

endmodule

// File: tb/tb_reg_file_rw.sv
// Bench for reg_file_rw: DUT a uses DEPTH=8, DUT b uses DEPTH=6 (held in
// reset except for the out-of-range scenario). Read expectations are queued
// when a read is driven and checked by a monitor when rd_valid appears.
module tb_reg_file_rw;
    import proc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rst_b = 1'b1;
    logic        clear = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rd_en0 = 1'b0, rd_en1 = 1'b0;
    logic [2:0]  rd_addr0 = '0, rd_addr1 = '0;

    logic [15:0] a_data0, a_data1, b_data0, b_data1;
    logic        a_vld0, a_vld1, a_err0, a_err1;
    logic        b_vld0, b_vld1, b_err0, b_err1;
    logic [7:0]  a_ev;
    logic [5:0]  b_ev;

    int n_cmp = 0;
    int n_fail = 0;

    rd_rsp_t qa0[$], qa1[$], qb0[$], qb1[$];

    always #5 clk = ~clk;

    reg_file_rw #(.WIDTH(16), .DEPTH(8)) dut_a (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en0(rd_en0), .rd_addr0(rd_addr0), .rd_data0(a_data0), .rd_valid0(a_vld0), .rd_err0(a_err0),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(a_data1), .rd_valid1(a_vld1), .rd_err1(a_err1),
        .entry_valid(a_ev)
    );

    reg_file_rw #(.WIDTH(16), .DEPTH(6)) dut_b (
        .clk(clk), .reset(rst_b), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en0(rd_en0), .rd_addr0(rd_addr0), .rd_data0(b_data0), .rd_valid0(b_vld0), .rd_err0(b_err0),
        .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(b_data1), .rd_valid1(b_vld1), .rd_err1(b_err1),
        .entry_valid(b_ev)
    );

    function automatic rd_rsp_t mk(input logic [15:0] d, input logic e);
        rd_rsp_t r;
        r.data = d;
        r.err  = e;
        return r;
    endfunction

    // Scoreboard monitor: outputs sampled on the falling edge.
    always @(negedge clk) begin
        rd_rsp_t e;
        if (a_vld0) begin
            n_cmp++;
            if (qa0.size() == 0) begin n_fail++; $display("FAIL sb_a0 unexpected valid data=%h err=%b", a_data0, a_err0); end
            else begin
                e = qa0.pop_front();
                if (a_data0 !== e.data || a_err0 !== e.err) begin
                    n_fail++; $display("FAIL sb_a0 got %h/%b want %h/%b", a_data0, a_err0, e.data, e.err);
                end
            end
        end
        if (a_vld1) begin
            n_cmp++;
            if (qa1.size() == 0) begin n_fail++; $display("FAIL sb_a1 unexpected valid data=%h err=%b", a_data1, a_err1); end
            else begin
                e = qa1.pop_front();
                if (a_data1 !== e.data || a_err1 !== e.err) begin
                    n_fail++; $display("FAIL sb_a1 got %h/%b want %h/%b", a_data1, a_err1, e.data, e.err);
                end
            end
        end
        if (b_vld0) begin
            n_cmp++;
            if (qb0.size() == 0) begin n_fail++; $display("FAIL sb_b0 unexpected valid data=%h err=%b", b_data0, b_err0); end
            else begin
                e = qb0.pop_front();
                if (b_data0 !== e.data || b_err0 !== e.err) begin
                    n_fail++; $display("FAIL sb_b0 got %h/%b want %h/%b", b_data0, b_err0, e.data, e.err);
                end
            end
        end
        if (b_vld1) begin
            n_cmp++;
            if (qb1.size() == 0) begin n_fail++; $display("FAIL sb_b1 unexpected valid data=%h err=%b", b_data1, b_err1); end
            else begin
                e = qb1.pop_front();
                if (b_data1 !== e.data || b_err1 !== e.err) begin
                    n_fail++; $display("FAIL sb_b1 got %h/%b want %h/%b", b_data1, b_err1, e.data, e.err);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        n_cmp++;
        if (a_vld0 !== 1'b0 || a_data0 !== 16'h0 || a_err0 !== 1'b0 || a_ev !== 8'h00) begin
            n_fail++; $display("FAIL reset_state got vld=%b data=%h err=%b ev=%h want 0/0000/0/00", a_vld0, a_data0, a_err0, a_ev);
        end
        reset = 1'b0;
        rd_en0 = 1'b1; rd_addr0 = 3'd3;
        qa0.push_back(mk(16'h0000, 1'b1));
        tick;
        rd_en0 = 1'b0;
        n_cmp++;
        if (a_ev !== 8'h00) begin n_fail++; $display("FAIL reset_ev got %h want 00", a_ev); end
        tick;
    endtask

    task automatic test_write_read;
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2933;
        tick;
        wr_addr = 3'd5; wr_data = 16'h1133;
        tick;
        wr_en = 1'b0;
        rd_en0 = 1'b1; rd_addr0 = 3'd2; qa0.push_back(mk(16'h2933, 1'b0));
        rd_en1 = 1'b1; rd_addr1 = 3'd5; qa1.push_back(mk(16'h1133, 1'b0));
        tick;
        rd_en0 = 1'b0; rd_en1 = 1'b0;
        n_cmp++;
        if (a_ev !== 8'h24) begin n_fail++; $display("FAIL wr_ev got %h want 24", a_ev); end
        tick;
        n_cmp++;
        if (a_vld0 !== 1'b0 || a_vld1 !== 1'b0) begin
            n_fail++; $display("FAIL wr_pulse got vld0=%b vld1=%b want 0/0", a_vld0, a_vld1);
        end
    endtask

    task automatic test_bypass;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h88F3;
        rd_en0 = 1'b1; rd_addr0 = 3'd4; qa0.push_back(mk(16'h88F3, 1'b0));
        rd_en1 = 1'b1; rd_addr1 = 3'd4; qa1.push_back(mk(16'h88F3, 1'b0));
        tick;
        wr_en = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b0;
        tick;
        n_cmp++;
        if (a_ev !== 8'h34) begin n_fail++; $display("FAIL byp_ev got %h want 34", a_ev); end
    endtask

    task automatic test_back_to_back;
        logic [2:0]  addrs[4];
        rd_rsp_t     exps[4];
        addrs = '{3'd2, 3'd5, 3'd4, 3'd0};
        exps  = '{mk(16'h2933, 1'b0), mk(16'h1133, 1'b0), mk(16'h88F3, 1'b0), mk(16'h0000, 1'b1)};
        for (int i = 0; i < 4; i++) begin
            rd_en0 = 1'b1; rd_addr0 = addrs[i];
            qa0.push_back(exps[i]);
            tick;
            n_cmp++;
            if (a_vld0 !== 1'b1) begin n_fail++; $display("FAIL b2b_vld[%0d] got %b want 1", i, a_vld0); end
        end
        rd_en0 = 1'b0;
        tick;
        n_cmp++;
        if (a_vld0 !== 1'b0 || a_data0 !== 16'h0 || a_err0 !== 1'b1) begin
            n_fail++; $display("FAIL b2b_hold got vld=%b data=%h err=%b want 0/0000/1", a_vld0, a_data0, a_err0);
        end
    endtask

    task automatic test_clear;
        clear = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hABCD;
        rd_en0 = 1'b1; rd_addr0 = 3'd2; qa0.push_back(mk(16'h2933, 1'b0));
        rd_en1 = 1'b1; rd_addr1 = 3'd7; qa1.push_back(mk(16'hABCD, 1'b0));
        tick;
        clear = 1'b0; wr_en = 1'b0;
        n_cmp++;
        if (a_ev !== 8'h80) begin n_fail++; $display("FAIL clr_ev got %h want 80", a_ev); end
        qa0.push_back(mk(16'h0000, 1'b1));
        qa1.push_back(mk(16'hABCD, 1'b0));
        tick;
        rd_en0 = 1'b0; rd_en1 = 1'b0;
        tick;
    endtask

    task automatic test_out_of_range;
        rst_b = 1'b0;
        tick;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h1234;
        tick;
        wr_addr = 3'd6; wr_data = 16'hFFFF;
        rd_en0 = 1'b1; rd_addr0 = 3'd6;
        rd_en1 = 1'b1; rd_addr1 = 3'd7;
        qa0.push_back(mk(16'hFFFF, 1'b0)); qb0.push_back(mk(16'h0000, 1'b1));
        qa1.push_back(mk(16'hABCD, 1'b0)); qb1.push_back(mk(16'h0000, 1'b1));
        tick;
        wr_en = 1'b0; rd_en1 = 1'b0;
        rd_addr0 = 3'd1;
        qa0.push_back(mk(16'h1234, 1'b0)); qb0.push_back(mk(16'h1234, 1'b0));
        n_cmp++;
        if (b_ev !== 6'b000010) begin n_fail++; $display("FAIL oor_ev_b got %b want 000010", b_ev); end
        n_cmp++;
        if (a_ev !== 8'hC2) begin n_fail++; $display("FAIL oor_ev_a got %h want C2", a_ev); end
        tick;
        rd_en0 = 1'b0;
        tick;
        rst_b = 1'b1;
    endtask

    task automatic test_reset_mid_read;
        rd_en0 = 1'b1; rd_addr0 = 3'd7;
        tick;
        rd_en0 = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (a_vld0 !== 1'b0 || a_data0 !== 16'h0 || a_ev !== 8'h00) begin
            n_fail++; $display("FAIL mid_rst got vld=%b data=%h ev=%h want 0/0000/00", a_vld0, a_data0, a_ev);
        end
        qa0.delete(); qa1.delete();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            n_cmp++;
            if (a_vld0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_late[%0d] got vld=%b want 0", i, a_vld0); end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_bypass;
        test_back_to_back;
        test_clear;
        test_out_of_range;
        test_reset_mid_read;
        tick;
        n_cmp++;
        if (qa0.size() + qa1.size() + qb0.size() + qb1.size() != 0) begin
            n_fail++; $display("FAIL sb_drain got %0d pending reads want 0", qa0.size() + qa1.size() + qb0.size() + qb1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
